// File: rtl/ga23_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ga23_pkg
// Purpose  : Shared constants, arbiter state type and index helper for GA23.
// Revision : 1.0  initial release
// ============================================================================
package ga23_pkg;

  localparam int NUM_LAYERS = 3;
  localparam int SDR_ADDR_W = 22;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  // (base + off) mod n for base < n and off < n, without a divider.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ga23_req_slot.sv
`default_nettype none
// ============================================================================
// Module   : ga23_req_slot
// Purpose  : One layer's pending fetch slot with stale and overrun tracking.
// Revision : 1.0  initial release
// ============================================================================
module ga23_req_slot
  import ga23_pkg::*;
#(
  parameter int ADDR_W = SDR_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              strobe,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              grant,
  input  logic              inflight_match,
  output logic              pending,
  output logic [ADDR_W-1:0] addr,
  output logic              stale,
  output logic              overrun
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= 1'b0;
      addr    <= '0;
      stale   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // A strobe in the grant cycle re-arms the slot; the grant used the old address.
      if (strobe) begin
        pending <= 1'b1;
        addr    <= addr_in;
        if (pending) begin
          overrun <= 1'b1;
        end
      end else if (grant) begin
        pending <= 1'b0;
      end

      if (grant) begin
        stale <= strobe;
      end else if (strobe && inflight_match) begin
        stale <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ga23_sdr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ga23_sdr_arbiter
// Purpose  : Round-robin sharing of one SDRAM read channel among tile layers.
// Revision : 1.0  initial release
// ============================================================================
module ga23_sdr_arbiter
  import ga23_pkg::*;
#(
  parameter int NUM_REQ = NUM_LAYERS,
  parameter int ADDR_W  = SDR_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_strobe,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ*32-1:0]     req_data,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic [ADDR_W-1:0]         sdr_addr,
  output logic                      sdr_req,
  input  logic [31:0]               sdr_data,
  input  logic                      sdr_rdy,
  output logic [NUM_REQ-1:0]        overrun
);

  localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [c_IDX_W-1:0]  r_owner;
  logic [c_IDX_W-1:0]  r_rr_ptr;
  logic [c_IDX_W-1:0]  w_sel;
  logic [c_IDX_W-1:0]  w_cand [NUM_REQ];
  logic                w_found;
  logic                w_deliver;
  logic [NUM_REQ-1:0]  w_grant;
  logic [NUM_REQ-1:0]  w_pending;
  logic [NUM_REQ-1:0]  w_stale;
  logic [NUM_REQ-1:0]  w_inflight;
  logic [ADDR_W-1:0]   w_slot_addr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign w_inflight[i] = (r_state == ARB_WAIT) && (r_owner == c_IDX_W'(i));

    ga23_req_slot #(
      .ADDR_W (ADDR_W)
    ) u_slot (
      .clk            (clk),
      .reset_n        (reset_n),
      .strobe         (req_strobe[i]),
      .addr_in        (req_addr[i*ADDR_W +: ADDR_W]),
      .grant          (w_grant[i]),
      .inflight_match (w_inflight[i]),
      .pending        (w_pending[i]),
      .addr           (w_slot_addr[i]),
      .stale          (w_stale[i]),
      .overrun        (overrun[i])
    );
  end

  // Search order starts at the round-robin pointer and wraps.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
    assign w_cand[k] = c_IDX_W'(wrap_idx(int'(r_rr_ptr), k, NUM_REQ));
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_pending[w_cand[k]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = '0;
    w_deliver   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_grant[w_sel] = 1'b1;
          w_state_nxt    = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (sdr_rdy) begin
          w_state_nxt = ARB_IDLE;
          w_deliver   = !w_stale[r_owner];
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_owner  <= '0;
      r_rr_ptr <= '0;
      sdr_req  <= 1'b0;
      sdr_addr <= '0;
      req_rdy  <= '0;
      req_data <= '0;
    end else begin
      req_rdy <= '0;
      if (|w_grant) begin
        sdr_req  <= 1'b1;
        sdr_addr <= w_slot_addr[w_sel];
        r_owner  <= w_sel;
        r_rr_ptr <= c_IDX_W'(wrap_idx(int'(w_sel), 1, NUM_REQ));
      end
      if ((r_state == ARB_WAIT) && sdr_rdy) begin
        sdr_req <= 1'b0;
      end
      // Responses to a re-strobed (stale) request are dropped.
      if (w_deliver) begin
        req_rdy[r_owner]                <= 1'b1;
        req_data[{r_owner, 5'd0} +: 32] <= sdr_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ga23_sdr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ga23_sdr_arbiter
// Purpose  : Self-checking bench for ga23_sdr_arbiter against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ga23_sdr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [2:0]  req_strobe;
  logic [65:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_rdy;
  logic [21:0] sdr_addr;
  logic        sdr_req;
  logic [31:0] sdr_data;
  logic        sdr_rdy;
  logic [2:0]  overrun;

  ga23_sdr_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_strobe (req_strobe),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_rdy    (req_rdy),
    .sdr_addr   (sdr_addr),
    .sdr_req    (sdr_req),
    .sdr_data   (sdr_data),
    .sdr_rdy    (sdr_rdy),
    .overrun    (overrun)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_pend [3];
  logic [21:0] m_addr [3];
  logic [31:0] m_data [3];
  bit          m_busy, m_stale, m_req;
  int          m_owner, m_rr;
  logic [21:0] m_saddr;
  logic [2:0]  m_rdy, m_ovr;

  int          auto_lat = 0;
  int          wait_cnt = 0;
  logic [21:0] grant_q [$];
  int          rdy_cnt [3];
  bit          prev_req = 1'b0;

  wire [124:0] dut_vec = {sdr_req, sdr_addr, req_rdy, overrun, req_data};

  function automatic logic [124:0] exp_vec();
    return {m_req, m_saddr, m_rdy, m_ovr, m_data[2], m_data[1], m_data[0]};
  endfunction

  function automatic void model_update();
    bit          np [3];
    logic [21:0] na [3];
    int          g;
    m_rdy = '0;
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        m_pend[i] = 0; m_addr[i] = '0; m_data[i] = '0;
      end
      m_busy = 0; m_stale = 0; m_req = 0; m_owner = 0; m_rr = 0;
      m_saddr = '0; m_ovr = '0;
      return;
    end
    np = m_pend;
    na = m_addr;
    if (!m_busy) begin
      g = -1;
      for (int k = 0; k < 3; k++)
        if (g < 0 && m_pend[(m_rr + k) % 3]) g = (m_rr + k) % 3;
      if (g >= 0) begin
        m_req = 1; m_saddr = m_addr[g]; m_owner = g; m_busy = 1;
        m_stale = req_strobe[g]; np[g] = 0; m_rr = (g + 1) % 3;
      end
    end else begin
      if (sdr_rdy) begin
        m_busy = 0; m_req = 0;
        if (!m_stale) begin
          m_data[m_owner] = sdr_data;
          m_rdy[m_owner]  = 1'b1;
        end
      end
      if (req_strobe[m_owner]) m_stale = 1;
    end
    for (int i = 0; i < 3; i++) begin
      if (req_strobe[i]) begin
        if (m_pend[i]) m_ovr[i] = 1'b1;
        np[i] = 1;
        na[i] = req_addr[i*22 +: 22];
      end
    end
    m_pend = np;
    m_addr = na;
  endfunction

  // Advance one clock: optional SDRAM auto-responder, model update, DUT edge.
  task automatic tick();
    if (auto_lat > 0 && m_req && !sdr_rdy) begin
      wait_cnt++;
      if (wait_cnt >= auto_lat) begin
        sdr_rdy  = 1'b1;
        sdr_data = $urandom;
        wait_cnt = 0;
      end
    end else if (!m_req) begin
      wait_cnt = 0;
    end
    model_update();
    @(posedge clk);
    #1;
    req_strobe = '0;
    sdr_rdy    = 1'b0;
    if (sdr_req && !prev_req) grant_q.push_back(sdr_addr);
    prev_req = sdr_req;
    for (int i = 0; i < 3; i++) if (req_rdy[i]) rdy_cnt[i]++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic clear_stats();
    grant_q.delete();
    for (int i = 0; i < 3; i++) rdy_cnt[i] = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL reset_state got %h exp 0", dut_vec);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_idle got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int s = 0; s < 9; s++) begin
      case (s)
        0: begin req_strobe = 3'b010; req_addr[43:22] = 22'h12340; end
        6: begin sdr_rdy = 1'b1; sdr_data = 32'hDEADBEEF; end
        default: ;
      endcase
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL single cyc%0d got %h exp %h", s, dut_vec, exp_vec());
      end
      if (s == 1) begin
        checks++;
        if (sdr_req !== 1'b1 || sdr_addr !== 22'h12340) begin
          errors++; $display("FAIL single_latency got req=%b addr=%h exp req=1 addr=12340", sdr_req, sdr_addr);
        end
      end
      if (s == 6) begin
        checks++;
        if (req_rdy !== 3'b010 || req_data !== {32'h0, 32'hDEADBEEF, 32'h0}) begin
          errors++; $display("FAIL single_return got rdy=%b data=%h exp rdy=010 data=%h", req_rdy, req_data, {32'h0, 32'hDEADBEEF, 32'h0});
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    clear_stats();
    auto_lat = 4;
    req_strobe = 3'b111;
    req_addr   = {22'h003000, 22'h002000, 22'h001000};
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL simul cyc%0d got %h exp %h", c, dut_vec, exp_vec());
      end
    end
    auto_lat = 0;
    checks++;
    if (grant_q.size() != 3 || grant_q[0] !== 22'h1000 || grant_q[1] !== 22'h2000 || grant_q[2] !== 22'h3000) begin
      errors++; $display("FAIL simul_order got %0d grants exp 3 in order 1000,2000,3000", grant_q.size());
    end
    checks++;
    if (rdy_cnt[0] != 1 || rdy_cnt[1] != 1 || rdy_cnt[2] != 1) begin
      errors++; $display("FAIL simul_rdy got %0d/%0d/%0d exp 1/1/1", rdy_cnt[0], rdy_cnt[1], rdy_cnt[2]);
    end
  endtask

  task automatic test_fairness();
    int issued;
    int c;
    do_reset();
    clear_stats();
    auto_lat = 2;
    req_strobe = 3'b101;
    req_addr   = {22'h200000, 22'h0, 22'h000000};
    issued = 2;
    c = 0;
    while (grant_q.size() < 20 && c < 400) begin
      for (int i = 0; i < 3; i += 2) begin
        if (m_rdy[i] && issued < 20) begin
          req_strobe[i] = 1'b1;
          req_addr[i*22 +: 22] = (i == 2 ? 22'h200000 : 22'h0) | 22'(issued);
          issued++;
        end
      end
      tick();
      c++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL fair cyc%0d got %h exp %h", c, dut_vec, exp_vec());
      end
    end
    for (int d = 0; d < 6; d++) tick();
    auto_lat = 0;
    checks++;
    if (grant_q.size() != 20) begin
      errors++; $display("FAIL fair_count got %0d grants exp 20", grant_q.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        checks++;
        if (grant_q[k][21] !== k[0]) begin
          errors++; $display("FAIL fair_alt grant%0d got layer_bit=%b exp %b", k, grant_q[k][21], k[0]);
        end
      end
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    clear_stats();
    for (int s = 0; s < 13; s++) begin
      case (s)
        0: begin req_strobe = 3'b100; req_addr[65:44] = 22'h222; end
        2: begin req_strobe = 3'b001; req_addr[21:0] = 22'h100; end
        3: begin req_strobe = 3'b001; req_addr[21:0] = 22'h200; end
        5, 9: begin sdr_rdy = 1'b1; sdr_data = $urandom; end
        default: ;
      endcase
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL overwr cyc%0d got %h exp %h", s, dut_vec, exp_vec());
      end
      if (s == 6) begin
        checks++;
        if (sdr_req !== 1'b1 || sdr_addr !== 22'h200) begin
          errors++; $display("FAIL overwr_addr got req=%b addr=%h exp req=1 addr=200", sdr_req, sdr_addr);
        end
      end
    end
    checks++;
    if (overrun !== 3'b001 || rdy_cnt[0] != 1) begin
      errors++; $display("FAIL overwr_flag got ovr=%b rdy0=%0d exp ovr=001 rdy0=1", overrun, rdy_cnt[0]);
    end
  endtask

  task automatic test_stale();
    do_reset();
    for (int s = 0; s < 9; s++) begin
      case (s)
        0: begin req_strobe = 3'b001; req_addr[21:0] = 22'h100; end
        2: begin req_strobe = 3'b001; req_addr[21:0] = 22'h300; end
        4: begin sdr_rdy = 1'b1; sdr_data = 32'h11111111; end
        7: begin sdr_rdy = 1'b1; sdr_data = 32'h22222222; end
        default: ;
      endcase
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL stale cyc%0d got %h exp %h", s, dut_vec, exp_vec());
      end
      if (s == 4) begin
        checks++;
        if (req_rdy !== 3'b000) begin
          errors++; $display("FAIL stale_drop got rdy=%b exp 000", req_rdy);
        end
      end
      if (s == 5) begin
        checks++;
        if (sdr_req !== 1'b1 || sdr_addr !== 22'h300) begin
          errors++; $display("FAIL stale_regrant got req=%b addr=%h exp req=1 addr=300", sdr_req, sdr_addr);
        end
      end
      if (s == 7) begin
        checks++;
        if (req_rdy !== 3'b001 || req_data[31:0] !== 32'h22222222) begin
          errors++; $display("FAIL stale_deliver got rdy=%b d0=%h exp rdy=001 d0=22222222", req_rdy, req_data[31:0]);
        end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: begin req_strobe = 3'b010; req_addr[43:22] = 22'h55; end
        2: reset_n = 1'b0;
        3: reset_n = 1'b1;
        4: begin sdr_rdy = 1'b1; sdr_data = 32'hCAFEF00D; end
        default: ;
      endcase
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rstwait cyc%0d got %h exp %h", s, dut_vec, exp_vec());
      end
      if (s == 2) begin
        checks++;
        if (dut_vec !== '0) begin
          errors++; $display("FAIL rstwait_clear got %h exp 0", dut_vec);
        end
      end
      if (s == 4) begin
        checks++;
        if (req_rdy !== 3'b000 || sdr_req !== 1'b0) begin
          errors++; $display("FAIL rstwait_late got rdy=%b req=%b exp 000/0", req_rdy, sdr_req);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 3; i++) begin
        req_strobe[i] = ($urandom_range(0, 4) == 0);
        req_addr[i*22 +: 22] = 22'($urandom);
      end
      sdr_data = $urandom;
      if (m_req && $urandom_range(0, 2) == 0) sdr_rdy = 1'b1;
      else if ($urandom_range(0, 19) == 0) sdr_rdy = 1'b1;
      reset_n = ($urandom_range(0, 149) != 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc%0d got %h exp %h", c, dut_vec, exp_vec());
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    req_strobe = '0;
    req_addr   = '0;
    sdr_rdy    = 1'b0;
    sdr_data   = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_overwrite();
    test_stale();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
